branch_history_table: RTL and testbench

- Dynamic branch predictor for the 5-stage MIPS pipeline. Replaces the single global prediction bit with a PC-indexed table of 2-bit saturating counters.
- Fetch stage reads a taken/not-taken prediction from the table.
- The ID-stage controller reports resolved beq/bne outcomes back to the table. The table updates the indexed counter and flags mispredictions to the PC-select logic.

---
 rtl/branch_history_table.sv | 114 +++++++++++
 tb/tb_branch_history_table.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// PC-indexed table of 2-bit saturating counters; `BHT_STATS_EN adds saturating branch/miss counters.
// IFPRED is 0-cycle with write-first bypass, IDPRED 1 cycle; WPCIR holds IDPRED and defers the update.
module branch_history_table #(
  parameter int         IDX_W      = 6,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [31:0]      IFPC,
  output logic             IFPRED,
  input  logic             WPCIR,
  input  logic             FLUSH,
  output logic             IDPRED,
  input  logic             UPD_VALID,
  input  logic [31:0]      UPD_PC,
  input  logic             UPD_TAKEN,
  output logic             MISPRED,
  output logic [CNT_W-1:0] BR_CNT,
  output logic [CNT_W-1:0] MISS_CNT
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0][1:0] tbl_q;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        wr_idx;
  logic                    upd_en;
  logic [1:0]              cur_cnt;
  logic [1:0]              nxt_cnt;
  logic                    pred;
  logic                    mis_raw;
  logic                    idpred_q;
  logic                    idpred_d;
  logic                    unused_pc;

  assign rd_idx    = IFPC[IDX_W+1:2];
  assign wr_idx    = UPD_PC[IDX_W+1:2];
  assign unused_pc = ^{IFPC[31:IDX_W+2], IFPC[1:0], UPD_PC[31:IDX_W+2], UPD_PC[1:0]};
  assign upd_en    = UPD_VALID & ~WPCIR;
  assign cur_cnt   = tbl_q[wr_idx];

  always_comb begin
    nxt_cnt = cur_cnt;
    if (UPD_TAKEN) begin
      if (cur_cnt != 2'b11) nxt_cnt = cur_cnt + 2'b01;
    end else begin
      if (cur_cnt != 2'b00) nxt_cnt = cur_cnt - 2'b01;
    end
  end

  assign pred    = (upd_en && (rd_idx == wr_idx)) ? nxt_cnt[1] : tbl_q[rd_idx][1];
  assign mis_raw = upd_en & (UPD_TAKEN != idpred_q);

  // Outputs are masked during reset so a live update cannot leak through the bypass.
  assign IFPRED  = pred & RESETN;
  assign MISPRED = mis_raw & RESETN;
  assign IDPRED  = idpred_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tbl_q <= {ENTRIES{INIT_STATE}};
    end else if (upd_en) begin
      tbl_q[wr_idx] <= nxt_cnt;
    end
  end

  always_comb begin
    idpred_d = idpred_q;
    if (FLUSH) begin
      idpred_d = 1'b0;
    end else if (!WPCIR) begin
      idpred_d = pred;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      idpred_q <= 1'b0;
    end else begin
      idpred_q <= idpred_d;
    end
  end

`ifdef BHT_STATS_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q;
  logic [CNT_W-1:0] miss_cnt_d;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd_en && (br_cnt_q != {CNT_W{1'b1}})) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (mis_raw && (miss_cnt_q != {CNT_W{1'b1}})) miss_cnt_d = miss_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign BR_CNT   = br_cnt_q;
  assign MISS_CNT = miss_cnt_q;
`else
  assign BR_CNT   = '0;
  assign MISS_CNT = '0;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: directed vector table, multi-cycle corner sequences, random vs. reference model.
module tb_branch_history_table;
  localparam int IDX_W = 6;
  localparam int CNT_W = 4;
  localparam int N     = 1 << IDX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int NV    = 22;

  logic             CLK = 1'b0;
  logic             RESETN;
  logic [31:0]      IFPC;
  logic             IFPRED;
  logic             WPCIR;
  logic             FLUSH;
  logic             IDPRED;
  logic             UPD_VALID;
  logic [31:0]      UPD_PC;
  logic             UPD_TAKEN;
  logic             MISPRED;
  logic [CNT_W-1:0] BR_CNT;
  logic [CNT_W-1:0] MISS_CNT;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_history_table #(.IDX_W(IDX_W), .INIT_STATE(2'b01), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESETN(RESETN), .IFPC(IFPC), .IFPRED(IFPRED), .WPCIR(WPCIR),
    .FLUSH(FLUSH), .IDPRED(IDPRED), .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC),
    .UPD_TAKEN(UPD_TAKEN), .MISPRED(MISPRED), .BR_CNT(BR_CNT), .MISS_CNT(MISS_CNT)
  );

  always #5 CLK = ~CLK;

  // wfv = {WPCIR, FLUSH, UPD_VALID}; exp = {IFPRED, IDPRED, MISPRED}
  typedef struct {
    logic [31:0] ifpc;
    logic [2:0]  wfv;
    logic [31:0] upc;
    logic        ut;
    logic [2:0]  exp;
  } vec_t;

  vec_t vecs[NV];

  int mdl_cnt[N];
  int mdl_id;
  int mdl_br;
  int mdl_miss;

  function automatic vec_t mk(input logic [31:0] ifpc, input logic [2:0] wfv,
                              input logic [31:0] upc, input logic ut, input logic [2:0] exp);
    vec_t v;
    v.ifpc = ifpc; v.wfv = wfv; v.upc = upc; v.ut = ut; v.exp = exp;
    return v;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_stats(input string nm, input int eb, input int em);
`ifdef BHT_STATS_EN
    chk({nm, "_br_cnt"}, int'(BR_CNT), eb);
    chk({nm, "_miss_cnt"}, int'(MISS_CNT), em);
`else
    chk({nm, "_br_cnt"}, int'(BR_CNT), 0);
    chk({nm, "_miss_cnt"}, int'(MISS_CNT), 0);
`endif
  endtask

  task automatic drive(input logic [31:0] ifpc, input logic [2:0] wfv,
                       input logic [31:0] upc, input logic ut);
    IFPC      = ifpc;
    WPCIR     = wfv[2];
    FLUSH     = wfv[1];
    UPD_VALID = wfv[0];
    UPD_PC    = upc;
    UPD_TAKEN = ut;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference: table of integers 0..3, prediction is "counter >= 2".
  task automatic model_cycle(input logic [31:0] ifpc, input logic [2:0] wfv,
                             input logic [31:0] upc, input logic ut);
    int ri, wi, nc, e_if, e_mis;
    bit upd;
    drive(ifpc, wfv, upc, ut);
    ri  = int'((ifpc >> 2) % N);
    wi  = int'((upc >> 2) % N);
    upd = wfv[0] && !wfv[2];
    nc  = mdl_cnt[wi];
    if (upd) nc = ut ? ((nc < 3) ? nc + 1 : 3) : ((nc > 0) ? nc - 1 : 0);
    e_if  = (upd && ri == wi) ? int'(nc >= 2) : int'(mdl_cnt[ri] >= 2);
    e_mis = int'(upd && (int'(ut) != mdl_id));
    #3;
    chk("rnd_ifpred", int'(IFPRED), e_if);
    chk("rnd_idpred", int'(IDPRED), mdl_id);
    chk("rnd_mispred", int'(MISPRED), e_mis);
    chk_stats("rnd", mdl_br, mdl_miss);
    next_cycle();
    if (upd) begin
      mdl_cnt[wi] = nc;
      mdl_br = sat_inc(mdl_br);
      if (e_mis != 0) mdl_miss = sat_inc(mdl_miss);
    end
    if (wfv[1]) mdl_id = 0;
    else if (!wfv[2]) mdl_id = e_if;
  endtask

  initial begin
    vecs[0]  = mk(32'h040, 3'b001, 32'h040, 1'b1, 3'b101);
    vecs[1]  = mk(32'h040, 3'b001, 32'h040, 1'b1, 3'b110);
    vecs[2]  = mk(32'h040, 3'b001, 32'h040, 1'b1, 3'b110);
    vecs[3]  = mk(32'h040, 3'b001, 32'h040, 1'b1, 3'b110);
    vecs[4]  = mk(32'h040, 3'b000, 32'h040, 1'b0, 3'b110);
    vecs[5]  = mk(32'h040, 3'b001, 32'h040, 1'b0, 3'b111);
    vecs[6]  = mk(32'h040, 3'b001, 32'h040, 1'b0, 3'b011);
    vecs[7]  = mk(32'h040, 3'b000, 32'h000, 1'b0, 3'b000);
    vecs[8]  = mk(32'h080, 3'b001, 32'h080, 1'b1, 3'b101);
    vecs[9]  = mk(32'h000, 3'b000, 32'h000, 1'b0, 3'b010);
    vecs[10] = mk(32'h080, 3'b101, 32'h010, 1'b1, 3'b100);
    vecs[11] = mk(32'h080, 3'b101, 32'h010, 1'b1, 3'b100);
    vecs[12] = mk(32'h080, 3'b001, 32'h010, 1'b1, 3'b101);
    vecs[13] = mk(32'h010, 3'b000, 32'h000, 1'b0, 3'b110);
    vecs[14] = mk(32'h010, 3'b001, 32'h010, 1'b0, 3'b011);
    vecs[15] = mk(32'h080, 3'b000, 32'h000, 1'b0, 3'b100);
    vecs[16] = mk(32'h080, 3'b110, 32'h000, 1'b0, 3'b110);
    vecs[17] = mk(32'h080, 3'b100, 32'h000, 1'b0, 3'b100);
    vecs[18] = mk(32'h004, 3'b001, 32'h104, 1'b1, 3'b101);
    vecs[19] = mk(32'h004, 3'b000, 32'h000, 1'b0, 3'b110);
    vecs[20] = mk(32'h007, 3'b000, 32'h000, 1'b0, 3'b110);
    vecs[21] = mk(32'h008, 3'b000, 32'h000, 1'b0, 3'b010);

    // Reset with a live matching update: outputs must stay quiet.
    RESETN = 1'b0;
    drive(32'h040, 3'b001, 32'h040, 1'b1);
    #3;
    chk("rst_ifpred", int'(IFPRED), 0);
    chk("rst_idpred", int'(IDPRED), 0);
    chk("rst_mispred", int'(MISPRED), 0);
    chk_stats("rst", 0, 0);
    @(posedge CLK);
    next_cycle();
    RESETN = 1'b1;

    for (int a = 0; a < N; a++) begin
      drive(32'(a * 4), 3'b000, 32'h0, 1'b0);
      #3;
      chk($sformatf("sweep_ifpred_%0h", a * 4), int'(IFPRED), 0);
      chk("sweep_idpred", int'(IDPRED), 0);
      chk("sweep_mispred", int'(MISPRED), 0);
      next_cycle();
    end

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].ifpc, vecs[k].wfv, vecs[k].upc, vecs[k].ut);
      #3;
      chk($sformatf("vec%0d_ifpred", k), int'(IFPRED), int'(vecs[k].exp[2]));
      chk($sformatf("vec%0d_idpred", k), int'(IDPRED), int'(vecs[k].exp[1]));
      chk($sformatf("vec%0d_mispred", k), int'(MISPRED), int'(vecs[k].exp[0]));
      next_cycle();
    end
    chk_stats("tbl", 10, 7);

    // Twenty mispredicted updates: IF looks at an untouched not-taken entry.
    for (int k = 0; k < 20; k++) begin
      drive(32'h0FC, 3'b001, 32'h200, 1'b1);
      #3;
      chk("sat_mispred", int'(MISPRED), 1);
      next_cycle();
    end
    chk_stats("sat", 15, 15);

    // Reset in the middle of a pending update on a saturated entry.
    drive(32'h000, 3'b001, 32'h200, 1'b0);
    #2;
    RESETN = 1'b0;
    #1;
    chk("midrst_ifpred", int'(IFPRED), 0);
    chk("midrst_mispred", int'(MISPRED), 0);
    chk("midrst_idpred", int'(IDPRED), 0);
    chk_stats("midrst", 0, 0);
    next_cycle();
    RESETN = 1'b1;
    drive(32'h000, 3'b001, 32'h000, 1'b0);
    #3;
    chk("postrst_ifpred", int'(IFPRED), 0);
    chk("postrst_mispred", int'(MISPRED), 0);
    next_cycle();
    drive(32'h000, 3'b001, 32'h000, 1'b1);
    #3;
    chk("postrst2_ifpred", int'(IFPRED), 0);
    chk("postrst2_mispred", int'(MISPRED), 1);
    chk_stats("postrst2", 1, 0);
    next_cycle();

    RESETN = 1'b0;
    #2;
    RESETN = 1'b1;
    for (int i = 0; i < N; i++) mdl_cnt[i] = 1;
    mdl_id   = 0;
    mdl_br   = 0;
    mdl_miss = 0;
    for (int k = 0; k < 1500; k++) begin
      model_cycle($urandom,
                  {($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), ($urandom_range(0, 1) == 1)},
                  $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
